// File: rtl/scalar_product_sched.sv
// rtl/scalar_product_sched.sv - time-multiplexes one multiply lane array over a vector pair and accumulates the dot product
module scalar_product_sched #(
   parameter int Nbits = 4,
   parameter int Ndata = 8,
   parameter int Nmul  = 2,
   localparam int L  = Ndata / Nmul,
   localparam int DW = 2*Nbits + $clog2(Ndata)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Ndata*Nbits-1:0]   A,
   input  logic [Ndata*Nbits-1:0]   B,
   output logic [L*Nbits-1:0]       multiplier,
   output logic [L*Nbits-1:0]       multiplicand,
   input  logic [L*2*Nbits-1:0]     mult_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [Ndata*2*Nbits-1:0] prod_vec,
   output logic [DW-1:0]            dot,
   output logic                     busy
);
   localparam int VW = Ndata*Nbits;
   localparam int CW = L*Nbits;
   localparam int PW = Ndata*2*Nbits;
   localparam int PC = L*2*Nbits;
   localparam int IW = (Nmul > 1) ? $clog2(Nmul) : 1;

   if (Nmul < 1 || Nmul > Ndata || (Ndata % Nmul) != 0) begin : g_bad_params
      $error("scalar_product_sched: Nmul must divide Ndata and lie in 1..Ndata");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [IW-1:0]    idx;
   logic [VW-1:0]    a_sh, b_sh;
   logic [DW-1:0]    lane_sum;
   logic [PW+PC-1:0] prod_cat;
   logic             last_pass;

   assign last_pass = (idx == IW'(Nmul - 1));
   assign prod_cat  = {mult_out, prod_vec};

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < L; i++)
         lane_sum = lane_sum + DW'(mult_out[i*2*Nbits +: 2*Nbits]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last_pass) state_nx = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Chunk 0 goes straight to the lanes; the rest waits in the shift registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_sh         <= '0;
         b_sh         <= '0;
         multiplier   <= '0;
         multiplicand <= '0;
         prod_vec     <= '0;
         dot          <= '0;
         idx          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh         <= A >> CW;
                  b_sh         <= B >> CW;
                  multiplier   <= A[CW-1:0];
                  multiplicand <= B[CW-1:0];
                  dot          <= '0;
                  idx          <= '0;
               end
            end
            RUN: begin
               prod_vec <= prod_cat[PW+PC-1 -: PW];
               dot      <= dot + lane_sum;
               if (last_pass) begin
                  multiplier   <= '0;
                  multiplicand <= '0;
               end else begin
                  multiplier   <= a_sh[CW-1:0];
                  multiplicand <= b_sh[CW-1:0];
                  a_sh         <= a_sh >> CW;
                  b_sh         <= b_sh >> CW;
                  idx          <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_scalar_product_sched.sv
// tb/tb_scalar_product_sched.sv - checks four scheduler instances (Nmul=1,2,4,8) against a vector-level model
module tb_scalar_product_sched;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] a_in [4];
   logic [31:0] b_in [4];
   logic [31:0] mplr [4];
   logic [31:0] mcnd [4];
   logic [63:0] pv [4];
   logic [10:0] dt [4];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 4; k++) begin : g
      localparam int NM = 1 << k;
      localparam int LL = 8 / NM;
      logic [LL*4-1:0] mr, md;
      logic [LL*8-1:0] mo;

      always_comb begin
         mo = '0;
         for (int i = 0; i < LL; i++)
            mo[i*8 +: 8] = 8'(mr[i*4 +: 4]) * 8'(md[i*4 +: 4]);
      end
      assign mplr[k] = 32'(mr);
      assign mcnd[k] = 32'(md);

      scalar_product_sched #(.Nbits(4), .Ndata(8), .Nmul(NM)) u_dut (
         .clk(clk), .reset(reset),
         .in_valid(in_valid[k]), .in_ready(in_ready[k]),
         .A(a_in[k]), .B(b_in[k]),
         .multiplier(mr), .multiplicand(md), .mult_out(mo),
         .out_valid(out_valid[k]), .out_ready(out_ready[k]),
         .prod_vec(pv[k]), .dot(dt[k]), .busy(busy[k])
      );
   end

   task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[nmul=%0d] at %0t: got %0h expected %0h", nm, 1 << k, $time, act, exp);
      end
   endtask

   // Model: ph=0 idle, ph=1..Nmul running pass ph-1, ph=Nmul+1 result held.
   int          ph [4]       = '{default: 0};
   int          last_dot [4] = '{default: 0};
   logic [63:0] last_pv [4]  = '{default: 64'h0};
   int          ea [4][8];
   int          eb [4][8];

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 4; k++) begin
         if (reset) begin
            ph[k] = 0; last_dot[k] = 0; last_pv[k] = '0;
         end else if (ph[k] == 0) begin
            if (in_valid[k]) begin
               for (int i = 0; i < 8; i++) begin
                  ea[k][i] = int'(a_in[k][i*4 +: 4]);
                  eb[k][i] = int'(b_in[k][i*4 +: 4]);
               end
               ph[k] = 1;
            end
         end else if (ph[k] <= (1 << k)) begin
            ph[k]++;
            if (ph[k] == (1 << k) + 1) begin
               last_dot[k] = 0;
               for (int i = 0; i < 8; i++) begin
                  last_pv[k][i*8 +: 8] = 8'(ea[k][i] * eb[k][i]);
                  last_dot[k] += ea[k][i] * eb[k][i];
               end
            end
         end else if (out_ready[k]) begin
            ph[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      int nm, l, p, ed;
      logic [31:0] em, ec;
      for (int k = 0; k < 4; k++) begin
         nm = 1 << k; l = 8 / nm; p = ph[k];
         em = '0; ec = '0; ed = 0;
         chk("in_ready", k, in_ready[k], p == 0);
         chk("out_valid", k, out_valid[k], p == nm + 1);
         chk("busy", k, busy[k], p != 0);
         if (p >= 1 && p <= nm) begin
            for (int i = 0; i < l; i++) begin
               em[i*4 +: 4] = 4'(ea[k][(p-1)*l + i]);
               ec[i*4 +: 4] = 4'(eb[k][(p-1)*l + i]);
            end
            for (int i = 0; i < (p-1)*l; i++) ed += ea[k][i] * eb[k][i];
         end else begin
            ed = last_dot[k];
         end
         chk("multiplier", k, mplr[k], em);
         chk("multiplicand", k, mcnd[k], ec);
         chk("dot", k, dt[k], ed);
         if (p == 0 || p == nm + 1) chk("prod_vec", k, pv[k], last_pv[k]);
      end
   end

   task automatic run_pair(input int k, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input bit disturb,
                           output logic [63:0] pv_o, output int dt_o,
                           output logic [31:0] m0, output logic [31:0] c0);
      int w, lat;
      @(negedge clk);
      w = 0;
      while (!in_ready[k] && w < 50) begin @(negedge clk); w++; end
      chk("idle_wait", k, in_ready[k], 1);
      a_in[k] = a; b_in[k] = b; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
      @(posedge clk); #1;
      in_valid[k] = 1'b0; a_in[k] = $urandom; b_in[k] = $urandom;
      m0 = mplr[k]; c0 = mcnd[k];
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid[k]) out_ready[k] = 1'($urandom_range(0, 1));
      end while (!out_valid[k] && lat < 40);
      out_ready[k] = 1'b0;
      chk("out_valid_wait", k, out_valid[k], 1);
      chk("latency", k, lat, 1 << k);
      pv_o = pv[k]; dt_o = int'(dt[k]);
      repeat (hold) begin
         @(negedge clk);
         if (disturb) begin in_valid[k] = ~in_valid[k]; a_in[k] = $urandom; end
      end
      @(negedge clk);
      in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask

   initial begin
      logic [63:0] pv_o;
      logic [31:0] m0, c0;
      int dt_o, cnt;
      reset = 1'b1; in_valid = '0; out_ready = '0;
      for (int k = 0; k < 4; k++) begin a_in[k] = '0; b_in[k] = '0; end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("rst_in_ready", k, in_ready[k], 1);
         chk("rst_dot", k, dt[k], 0);
         chk("rst_prod", k, pv[k], 0);
         chk("rst_multiplier", k, mplr[k], 0);
      end
      reset = 1'b0;

      for (int k = 0; k < 4; k++) begin
         run_pair(k, 32'h76543210, 32'h01234567, 0, 1'b0, pv_o, dt_o, m0, c0);
         chk("ref_dot", k, dt_o, 56);
         chk("ref_prod", k, pv_o, 64'h00060A0C0C0A0600);
         case (k)
            0: chk("chunk0_a", k, m0, 32'h76543210);
            1: chk("chunk0_a", k, m0, 32'h00003210);
            2: chk("chunk0_a", k, m0, 32'h00000010);
            default: chk("chunk0_b", k, c0, 32'h00000007);
         endcase
      end

      for (int k = 1; k < 4; k += 2) begin
         run_pair(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, pv_o, dt_o, m0, c0);
         chk("max_dot", k, dt_o, 1800);
         chk("max_prod", k, pv_o, 64'hE1E1E1E1E1E1E1E1);
      end

      run_pair(1, $urandom, $urandom, 10, 1'b1, pv_o, dt_o, m0, c0);
      run_pair(1, 32'h12345678, 32'h87654321, 0, 1'b0, pv_o, dt_o, m0, c0);
      chk("after_hold_dot", 1, dt_o, 120);

      @(negedge clk);
      a_in[2] = $urandom; b_in[2] = $urandom; in_valid[2] = 1'b1;
      @(posedge clk); #1;
      in_valid[2] = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("abort_dot", 2, dt[2], 0);
      chk("abort_prod", 2, pv[2], 0);
      chk("abort_multiplier", 2, mplr[2], 0);
      chk("abort_in_ready", 2, in_ready[2], 1);
      chk("abort_out_valid", 2, out_valid[2], 0);
      chk("abort_busy", 2, busy[2], 0);
      @(negedge clk);
      reset = 1'b0;
      run_pair(2, 32'h11111111, 32'h22222222, 0, 1'b0, pv_o, dt_o, m0, c0);
      chk("post_abort_dot", 2, dt_o, 16);

      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         in_valid[k] = 1'b1; out_ready[k] = 1'b1; cnt = 0;
         for (int c = 0; c < 8 * ((1 << k) + 2); c++) begin
            if (in_ready[k]) cnt++;
            a_in[k] = $urandom; b_in[k] = $urandom;
            @(negedge clk);
         end
         in_valid[k] = 1'b0;
         chk("b2b_accepts", k, cnt, 8);
         repeat ((1 << k) + 2) @(negedge clk);
         out_ready[k] = 1'b0;
      end

      for (int t = 0; t < 40; t++)
         run_pair($urandom_range(0, 3), $urandom, $urandom, $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), pv_o, dt_o, m0, c0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/scalar_product_sched.md
Name: scalar_product_sched

Overview:
- Sequencer that time-multiplexes one shared, purely combinational `multiply` lane array across a full Ndata-element vector pair.
- Accepts vectors A and B through a valid/ready handshake and slices them into Nmul chunks of Ndata/Nmul elements. It drives one chunk per cycle into the external multiply instance.
- Collects the element-wise product vector and accumulates the unsigned scalar (dot) product.
- Presents both results through a valid/ready output handshake. Sits between the vector source and the downstream matmul accumulation logic.

Parameters:
- Nbits, 4, width of one unsigned element.
- Ndata, 8, elements per input vector.
- Nmul, 2, passes per vector. The multiply instance has Ndata/Nmul lanes. Requires Ndata % Nmul == 0 and 1 <= Nmul <= Ndata; otherwise $error at elaboration.
- Local L = Ndata/Nmul (lanes).
- Local DW = 2*Nbits + $clog2(Ndata) (dot width).

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous, active-high.
- in_valid, input, 1, A/B valid.
- in_ready, output, 1, block can accept A/B.
- A, input, Ndata*Nbits, vector A; element i at bits [i*Nbits +: Nbits].
- B, input, Ndata*Nbits, vector B; same packing as A.
- multiplier, output, L*Nbits, chunk of A to the multiply instance.
- multiplicand, output, L*Nbits, chunk of B to the multiply instance.
- mult_out, input, L*2*Nbits, lane products from the multiply instance (combinational, same cycle).
- out_valid, output, 1, results valid.
- out_ready, input, 1, downstream accepts results.
- prod_vec, output, Ndata*2*Nbits, element products; element i at [i*2*Nbits +: 2*Nbits].
- dot, output, DW, sum of all Ndata products.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- **Reset values** (asynchronous, immediate): state=IDLE; in_ready=1; out_valid=0; busy=0; multiplier=0; multiplicand=0; prod_vec=0; dot=0; pass counter=0; internal A/B shift registers=0.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - in_ready=1.
  - On an edge with in_valid=1: latch A>>(L*Nbits) and B>>(L*Nbits) into shift regs. Register multiplier/multiplicand = chunk 0 (bits [L*Nbits-1:0]). Clear the accumulator and set idx=0. Go to RUN.
  - multiplier/multiplicand are held at 0 while in IDLE.
- **RUN** (exactly Nmul cycles), on each edge:
  - prod_vec <= {mult_out, prod_vec[Ndata*2*Nbits-1 : L*2*Nbits]} (shift in from the top, so chunk 0 ends in the low bits).
  - dot <= dot + sum of the L lane products of mult_out, zero-extended to DW.
  - If idx < Nmul-1: drive the next chunk from the shift regs, shift them by L*Nbits, idx++.
  - Else: multiplier/multiplicand <= 0, go to DONE.
  - in_ready=0.
- **DONE:**
  - out_valid=1; prod_vec and dot held stable.
  - On an edge with out_ready=1: out_valid drops and the state returns to IDLE (in_ready=1 next cycle).
  - No acceptance in DONE: one vector pair in flight at a time.
- **Latency:** out_valid rises on the Nmul-th edge after the accepting edge. Throughput is one vector pair per Nmul+2 cycles when out_ready is held at 1.
- **Arithmetic:** all unsigned. DW guarantees no overflow; e.g. Nbits=4, Ndata=8: max 8*225=1800 < 2048.
- **Nmul=1:** single RUN cycle. The multiply sees the full vectors; out_valid is asserted one edge after acceptance.
- **Nmul=Ndata:** one lane; Ndata RUN cycles.
- **Backpressure:** out_valid stays high and outputs stay stable indefinitely while out_ready=0. in_valid is ignored during RUN and DONE.
- **Input stability:** A and B are sampled only on the accepting edge, so later changes have no effect.
- **Reset mid-operation:** aborts immediately to reset values. No out_valid is produced for the aborted pair.
- **Early out_ready:** out_ready asserted in IDLE or RUN has no effect.

Test Plan:
- Defaults (Nbits=4, Ndata=8, Nmul=2); A={7,6,5,4,3,2,1,0} and B={0,1,2,3,4,5,6,7} (MSB→LSB); in_valid pulse, out_ready=1 -> out_valid 2 edges after accept. prod_vec elements 0..7 = 0,6,10,12,12,10,6,0; dot=56. Chunk 0 (A elems 0-3) is seen on multiplier first.
- Same vectors with Nmul=1 and Nmul=8 -> identical prod_vec/dot. out_valid after 1 and 8 edges respectively; multiplier width 32 and 4 bits respectively.
- All elements of A and B = 15 -> every product 225, dot=1800, no overflow.
- Hold out_ready=0 for 10 cycles after out_valid; toggle in_valid and change A -> out_valid, prod_vec and dot stable, in_ready=0. The first pair with out_ready=1 completes, then the next pair is accepted and its result is correct.
- Assert reset on the 2nd RUN cycle (Nmul=4) -> all outputs 0 immediately, in_ready=1, no out_valid. A new pair afterwards gives a correct dot.
- Back-to-back pairs with in_valid held high and out_ready=1 -> accepts every Nmul+2 cycles, results in order, accumulator cleared between pairs (second dot is not the cumulative sum).
